// File: rtl/score_bcd_readout_if.sv
// -----------------------------------------------------------------------------
// score_bcd_readout_if
// Handshake and data bundle between the score summation stage / display path
// and the score_bcd_readout converter.
//   total_Score : binary score, sampled on an accepted start
//   start       : conversion request (level-sampled)
//   busy        : conversion in progress
//   done        : one-cycle pulse, digit outputs just updated
//   digit4..0   : BCD ten-thousands..ones of the last completed conversion
// Modports: master (requester / display side), slave (converter).
// -----------------------------------------------------------------------------
interface score_bcd_readout_if #(
    parameter int SCORE_W = 14
);
    logic [SCORE_W-1:0] total_Score;
    logic               start;
    logic               busy;
    logic               done;
    logic [3:0]         digit4;
    logic [3:0]         digit3;
    logic [3:0]         digit2;
    logic [3:0]         digit1;
    logic [3:0]         digit0;

    modport master (
        output total_Score, start,
        input  busy, done, digit4, digit3, digit2, digit1, digit0
    );

    modport slave (
        input  total_Score, start,
        output busy, done, digit4, digit3, digit2, digit1, digit0
    );
endinterface

// File: rtl/score_bcd_readout.sv
// -----------------------------------------------------------------------------
// score_bcd_readout
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock)
// for the on-screen score text and HEX displays. The last completed result is
// held on the digit outputs between conversions.
//
// Ports:
//   Clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : score_bcd_readout_if.slave (total_Score, start, busy, done,
//              digit4..digit0)
// Parameters:
//   SCORE_W  : binary input width, 1..16 (default 14)
// Configuration macro:
//   SCORE_BCD_SATURATE_EN : when defined, inputs above 9999 are clamped to
//                           9999 on capture and digit4 stays 0.
// -----------------------------------------------------------------------------
module score_bcd_readout #(
    parameter int SCORE_W = 14
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    score_bcd_readout_if.slave    bus
);

    localparam int CNT_W = $clog2(SCORE_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic               busy_c;
    logic [CNT_W-1:0]   count;
    logic [SCORE_W-1:0] bin;
    logic [SCORE_W-1:0] capture;
    logic [19:0]        bcd;
    logic [19:0]        bcd_adj;
    logic [19:0]        result;
    logic               done_q;

    // Value loaded into the binary shift register on an accepted start.
`ifdef SCORE_BCD_SATURATE_EN
    always_comb begin
        capture = bus.total_Score;
        if (17'(bus.total_Score) > 17'd9999)
            capture = SCORE_W'(9999);
    end
`else
    always_comb begin
        capture = bus.total_Score;
    end
`endif

    // Add-3 correction of every nibble that would overflow past 9 when doubled.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next-state and outputs
    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_next = SHIFT;
            end
            SHIFT: begin
                busy_c = 1'b1;
                if (count == CNT_W'(SCORE_W - 1))
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture, shift, and result register.
    // done is registered alongside the result load so both appear on the
    // same edge, one cycle after the final shift.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count  <= '0;
            bin    <= '0;
            bcd    <= '0;
            result <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin   <= capture;
                        bcd   <= '0;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[18:0], bin, 1'b0};
                    count      <= count + 1'b1;
                end
                DONE: begin
`ifdef SCORE_BCD_SATURATE_EN
                    result <= {4'd0, bcd[15:0]};
`else
                    result <= bcd;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_q;
    assign bus.digit4 = result[19:16];
    assign bus.digit3 = result[15:12];
    assign bus.digit2 = result[11:8];
    assign bus.digit1 = result[7:4];
    assign bus.digit0 = result[3:0];

endmodule

// File: tb/tb_score_bcd_readout.sv
// -----------------------------------------------------------------------------
// tb_score_bcd_readout
// Self-checking bench for score_bcd_readout: directed corner values plus
// random scores, compared against a decimal arithmetic reference model.
// Honours SCORE_BCD_SATURATE_EN in the reference model.
// -----------------------------------------------------------------------------
module tb_score_bcd_readout;

    localparam int SCORE_W = 14;
    localparam int LAT     = SCORE_W + 1;

    logic Clk;
    logic Reset_n;
    int   n_cmp;
    int   n_err;
    logic [19:0] exp_digits;

    score_bcd_readout_if #(.SCORE_W(SCORE_W)) bus ();

    score_bcd_readout #(.SCORE_W(SCORE_W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: five decimal digits by plain division.
    function automatic logic [19:0] model(input int v);
        int x;
        int p;
        logic [19:0] d;
        x = v;
`ifdef SCORE_BCD_SATURATE_EN
        if (x > 9999) x = 9999;
`endif
        d = '0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            d[4*i +: 4] = 4'((x / p) % 10);
            p = p * 10;
        end
        return d;
    endfunction

    function automatic logic [19:0] digits();
        return {bus.digit4, bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    // One full conversion; optionally pulses start again mid-conversion.
    task automatic run_conv(input int v, input bit inject);
        int busy_cnt;
        int done_cnt;
        int done_at;
        int ovl;
        int early;
        busy_cnt = 0; done_cnt = 0; done_at = -1; ovl = 0; early = 0;
        @(negedge Clk);
        bus.start       = 1'b1;
        bus.total_Score = SCORE_W'(v);
        for (int k = 0; k <= LAT + 1; k++) begin
            @(posedge Clk);
            #1;
            if (k == 0) begin
                bus.start       = 1'b0;
                bus.total_Score = SCORE_W'($urandom);
            end
            if (inject && k == 5) begin
                bus.start       = 1'b1;
                bus.total_Score = SCORE_W'(1);
            end
            if (inject && k == 6)
                bus.start = 1'b0;
            if (bus.busy && bus.done) ovl++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k < LAT && digits() !== exp_digits) early++;
        end
        exp_digits = model(v);
        check("busy_len", busy_cnt, SCORE_W);
        check("done_lat", done_at, LAT);
        check("done_cnt", done_cnt, 1);
        check("overlap", ovl, 0);
        check("hold_before_done", early, 0);
        check("digits", digits(), exp_digits);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_digits = '0;
        Reset_n = 1'b0;
        bus.start = 1'b0;
        bus.total_Score = '0;

        // Reset with random activity on the inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            bus.start       = 1'($urandom);
            bus.total_Score = SCORE_W'($urandom);
            @(posedge Clk);
            #1;
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_digits", digits(), 0);
        end
        @(negedge Clk);
        bus.start = 1'b0;
        Reset_n   = 1'b1;

        run_conv(0, 1'b0);
        run_conv(16383, 1'b0);
        run_conv(9999, 1'b0);
        run_conv(1234, 1'b0);
        run_conv(4660, 1'b1);

        // Reset in the middle of a conversion of 16383
        @(negedge Clk);
        bus.start       = 1'b1;
        bus.total_Score = SCORE_W'(16383);
        @(posedge Clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_digits", digits(), 0);
        exp_digits = '0;
        @(negedge Clk);
        Reset_n = 1'b1;
        run_conv(42, 1'b0);

        // Random scores
        for (int i = 0; i < 20; i++)
            run_conv(int'($urandom_range(0, 16383)), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
